// File: rtl/time_of_day_cnt.sv
// time_of_day_cnt: 24-hour BCD HH:MM:SS counter with hour/minute set modes.
//
// Ports:
//   CLK       in   system clock (50 MHz)
//   RST       in   synchronous active-high reset
//   EN1HZ     in   single-cycle 1 Hz tick
//   SEL       in   single-cycle pulse, advances RUN -> SET_HR -> SET_MIN -> RUN
//   INC       in   single-cycle pulse, increments the field being set
//   HOUR      out  BCD hour   (tens 0-2, units 0-9)
//   MIN       out  BCD minute (tens 0-5, units 0-9)
//   SEC       out  BCD second (tens 0-5, units 0-9)
//   MODE      out  2'b00 RUN, 2'b01 SET_HR, 2'b10 SET_MIN
//   DAY_TICK  out  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
module time_of_day_cnt #(
  parameter logic [7:0] INIT_HR  = 8'h00,
  parameter logic [7:0] INIT_MIN = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN1HZ,
  input  logic       SEL,
  input  logic       INC,
  output logic [7:0] HOUR,
  output logic [7:0] MIN,
  output logic [7:0] SEC,
  output logic [1:0] MODE,
  output logic       DAY_TICK
);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_e;

  mode_e      mode_q, mode_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       day_tick_q, day_tick_d;

  // BCD increment modulo 60 (used for both seconds and minutes)
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {4'(v[7:4] + 4'd1), 4'd0};
    end else begin
      r = {v[7:4], 4'(v[3:0] + 4'd1)};
    end
    return r;
  endfunction

  // BCD increment modulo 24; 09 -> 10 and 19 -> 20 go through the units wrap
  function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)          r = 8'h00;
    else if (v[3:0] == 4'd9) r = {4'(v[7:4] + 4'd1), 4'd0};
    else                     r = {v[7:4], 4'(v[3:0] + 4'd1)};
    return r;
  endfunction

  // Mode state register
  always_ff @(posedge CLK) begin
    if (RST) mode_q <= MODE_RUN;
    else     mode_q <= mode_d;
  end

  // Mode next-state: only SEL moves the mode
  always_comb begin
    mode_d = mode_q;
    if (SEL) begin
      case (mode_q)
        MODE_RUN:     mode_d = MODE_SET_HR;
        MODE_SET_HR:  mode_d = MODE_SET_MIN;
        MODE_SET_MIN: mode_d = MODE_RUN;
        default:      mode_d = MODE_RUN;
      endcase
    end
  end

  // Time fields and day tick next values
  always_comb begin
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    day_tick_d = 1'b0;
    case (mode_q)
      MODE_RUN: begin
        if (EN1HZ) begin
          sec_d = bcd_inc60(sec_q);
          if (sec_q == 8'h59) begin
            min_d = bcd_inc60(min_q);
            if (min_q == 8'h59) begin
              hour_d = bcd_inc24(hour_q);
              if (hour_q == 8'h23) day_tick_d = 1'b1;
            end
          end
        end
        // Entering SET_HR zeroes seconds, even on top of a same-cycle tick
        if (SEL) sec_d = 8'h00;
      end
      MODE_SET_HR: begin
        if (!SEL && INC) hour_d = bcd_inc24(hour_q);
      end
      MODE_SET_MIN: begin
        if (!SEL && INC) min_d = bcd_inc60(min_q);
      end
      default: ;
    endcase
  end

  // Time field registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      hour_q     <= INIT_HR;
      min_q      <= INIT_MIN;
      sec_q      <= 8'h00;
      day_tick_q <= 1'b0;
    end else begin
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      day_tick_q <= day_tick_d;
    end
  end

  assign HOUR     = hour_q;
  assign MIN      = min_q;
  assign SEC      = sec_q;
  assign MODE     = mode_q;
  assign DAY_TICK = day_tick_q;

endmodule
